// File: rtl/imm_control_fsm_pkg.sv
// Shared definitions for the immediate-instruction control FSM.
// Holds the FSM state encodings, the instruction classes produced by the
// decoder, the ALU function-select codes, the LEGv8 opcode patterns for the
// immediate instructions, and the bit offsets of every field inside the
// datapath control word, together with a helper that packs those fields.
package imm_control_fsm_pkg;

   // FSM states; the encoding is visible on the top-level state port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EXEC  = 2'b01,
      ST_MERGE = 2'b10
   } fsmStateT;

   // What the latched instruction turned out to be after decoding.
   typedef enum logic [1:0] {
      OP_ARITH   = 2'b00,
      OP_MOVZ    = 2'b01,
      OP_MOVK    = 2'b10,
      OP_ILLEGAL = 2'b11
   } opClassT;

   // ALU function-select codes.
   localparam logic [4:0] FSEL_AND = 5'b00000;
   localparam logic [4:0] FSEL_ORR = 5'b00100;
   localparam logic [4:0] FSEL_ADD = 5'b01000;
   localparam logic [4:0] FSEL_SUB = 5'b01001;
   localparam logic [4:0] FSEL_EOR = 5'b01100;

   // Ten-bit opcodes found in instruction[31:22].
   localparam logic [9:0] OPC_ADDI  = 10'b1001000100;
   localparam logic [9:0] OPC_ADDIS = 10'b1011000100;
   localparam logic [9:0] OPC_SUBI  = 10'b1101000100;
   localparam logic [9:0] OPC_SUBIS = 10'b1111000100;
   localparam logic [9:0] OPC_ANDI  = 10'b1001001000;
   localparam logic [9:0] OPC_ANDIS = 10'b1111001000;
   localparam logic [9:0] OPC_ORRI  = 10'b1011001000;
   localparam logic [9:0] OPC_EORI  = 10'b1101001000;

   // Nine-bit wide-move opcodes found in instruction[31:23].
   localparam logic [8:0] OPC_MOVZ = 9'b110100101;
   localparam logic [8:0] OPC_MOVK = 9'b111100101;

   // Register 31 reads as zero, which lets MOVZ be done as XZR | K.
   localparam logic [4:0] REG_XZR = 5'd31;

   // Datapath select values used by every immediate instruction.
   localparam logic [1:0] PSEL_HOLD = 2'b00;
   localparam logic [1:0] PSEL_LOAD = 2'b01;
   localparam logic [1:0] DSEL_ALU  = 2'b01;

   // Control word layout, LSB upward:
   // SL, PCsel, Bsel, Dsel[1:0], ramW, regW, Fsel[4:0], SB, SA, DA, Psel[1:0].
   localparam int CW_SL_POS       = 0;
   localparam int CW_PCSEL_POS    = 1;
   localparam int CW_BSEL_POS     = 2;
   localparam int CW_DSEL_POS     = 3;
   localparam int CW_RAMW_POS     = 5;
   localparam int CW_REGW_POS     = 6;
   localparam int CW_FSEL_POS     = 7;
   localparam int CW_SB_POS       = 12;
   localparam int CW_SA_POS       = 17;
   localparam int CW_DA_POS       = 22;
   localparam int CW_PSEL_POS     = 27;
   localparam int CW_FIELDS_WIDTH = 29;

   // Unpacked view of the control word so the FSM can set fields by name.
   typedef struct packed {
      logic [1:0] psel;
      logic [4:0] da;
      logic [4:0] sa;
      logic [4:0] sb;
      logic [4:0] fsel;
      logic       regW;
      logic       ramW;
      logic [1:0] dsel;
      logic       bsel;
      logic       pcSel;
      logic       sl;
   } controlFieldsT;

   // Places each named field at its offset in the flat control word.
   function automatic logic [CW_FIELDS_WIDTH-1:0] packControl(input controlFieldsT f);
      logic [CW_FIELDS_WIDTH-1:0] word;
      word                       = '0;
      word[CW_PSEL_POS +: 2]     = f.psel;
      word[CW_DA_POS +: 5]       = f.da;
      word[CW_SA_POS +: 5]       = f.sa;
      word[CW_SB_POS +: 5]       = f.sb;
      word[CW_FSEL_POS +: 5]     = f.fsel;
      word[CW_REGW_POS]          = f.regW;
      word[CW_RAMW_POS]          = f.ramW;
      word[CW_DSEL_POS +: 2]     = f.dsel;
      word[CW_BSEL_POS]          = f.bsel;
      word[CW_PCSEL_POS]         = f.pcSel;
      word[CW_SL_POS]            = f.sl;
      return word;
   endfunction

endpackage

// File: rtl/imm_control_fsm_k_gen.sv
// imm_k_gen: builds the immediate operands for the datapath B input.
//   imm12   - arithmetic/logic immediate, zero-extended to DATA_WIDTH
//   imm16   - wide-move immediate
//   hw      - wide-move halfword select, shift amount is 16*hw
//   arithK  - zero-extended imm12
//   movK    - imm16 shifted into the selected halfword
//   maskK   - all ones except the selected halfword (used by MOVK to clear it)
// Shifts are done at 64 bits and truncated, so a 32-bit build simply loses
// the upper halfwords; the FSM flags those cases as illegal.
module imm_k_gen #(
   parameter int DATA_WIDTH = 64
) (
   input  logic [11:0]           imm12,
   input  logic [15:0]           imm16,
   input  logic [1:0]            hw,
   output logic [DATA_WIDTH-1:0] arithK,
   output logic [DATA_WIDTH-1:0] movK,
   output logic [DATA_WIDTH-1:0] maskK
);

   logic [5:0]  shiftAmount;
   logic [63:0] movWide;
   logic [63:0] maskWide;

   // All three operands are pure functions of the immediate fields, so they
   // are computed combinationally and selected by the FSM afterwards.
   always_comb begin
      shiftAmount = {hw, 4'b0000};
      movWide     = {48'd0, imm16} << shiftAmount;
      maskWide    = ~({48'd0, 16'hFFFF} << shiftAmount);
      arithK      = DATA_WIDTH'(imm12);
      movK        = movWide[DATA_WIDTH-1:0];
      maskK       = maskWide[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/imm_control_fsm.sv
// imm_control_fsm: multi-cycle control unit for LEGv8 immediate instructions.
// Accepts one instruction from fetch while IDLE, latches it, and then drives
// the datapath control word and immediate K for one EXEC cycle (two cycles,
// EXEC then MERGE, for MOVK which clears and then fills a halfword).
// Ports:
//   clock, reset   - single clock, synchronous active-high reset
//   instr_valid    - fetch is offering an instruction
//   instruction    - the offered 32-bit instruction word
//   instr_ready    - high only in IDLE; accept = instr_valid & instr_ready
//   controlWord    - {Psel,DA,SA,SB,Fsel,regW,ramW,Dsel,Bsel,PCsel,SL}
//   K              - immediate operand for the datapath B input
//   state          - current FSM state (IDLE=00, EXEC=01, MERGE=10)
//   illegal        - high during the single EXEC cycle of a bad instruction
module imm_control_fsm
   import imm_control_fsm_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CW_WIDTH   = 29
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  instr_valid,
   input  logic [31:0]           instruction,
   output logic                  instr_ready,
   output logic [CW_WIDTH-1:0]   controlWord,
   output logic [DATA_WIDTH-1:0] K,
   output logic [1:0]            state,
   output logic                  illegal
);

   fsmStateT              stateReg;
   fsmStateT              stateNext;
   logic [31:0]           instrLatched;
   logic                  accept;
   opClassT               opClass;
   logic [4:0]            arithFsel;
   logic                  setFlags;
   logic                  highHalfOn32;
   logic [DATA_WIDTH-1:0] arithK;
   logic [DATA_WIDTH-1:0] movK;
   logic [DATA_WIDTH-1:0] maskK;
   controlFieldsT         fields;

   assign instr_ready = (stateReg == ST_IDLE);
   assign accept      = instr_valid && instr_ready;
   assign state       = stateReg;

   // A 32-bit datapath has no halfwords 2 and 3, so any wide move that
   // selects them cannot be executed.
   assign highHalfOn32 = (DATA_WIDTH == 32) ? instrLatched[22] : 1'b0;

   imm_k_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) kGen (
      .imm12  (instrLatched[21:10]),
      .imm16  (instrLatched[20:5]),
      .hw     (instrLatched[22:21]),
      .arithK (arithK),
      .movK   (movK),
      .maskK  (maskK)
   );

   // State and instruction registers. The instruction is captured on the
   // accepting edge and held until the next accept, so the outputs stay
   // stable for the whole EXEC/MERGE sequence. Reset clears both, which also
   // aborts any instruction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         stateReg     <= ST_IDLE;
         instrLatched <= '0;
      end else begin
         stateReg <= stateNext;
         if (accept) begin
            instrLatched <= instruction;
         end
      end
   end

   // Decode the latched instruction. Wide moves are matched on nine opcode
   // bits first; everything else is matched on ten bits. Anything that does
   // not match falls through to the illegal class.
   always_comb begin
      opClass   = OP_ILLEGAL;
      arithFsel = FSEL_AND;
      setFlags  = 1'b0;
      if (instrLatched[31:23] == OPC_MOVZ) begin
         opClass = highHalfOn32 ? OP_ILLEGAL : OP_MOVZ;
      end else if (instrLatched[31:23] == OPC_MOVK) begin
         opClass = highHalfOn32 ? OP_ILLEGAL : OP_MOVK;
      end else begin
         case (instrLatched[31:22])
            OPC_ADDI:  begin opClass = OP_ARITH; arithFsel = FSEL_ADD; end
            OPC_ADDIS: begin opClass = OP_ARITH; arithFsel = FSEL_ADD; setFlags = 1'b1; end
            OPC_SUBI:  begin opClass = OP_ARITH; arithFsel = FSEL_SUB; end
            OPC_SUBIS: begin opClass = OP_ARITH; arithFsel = FSEL_SUB; setFlags = 1'b1; end
            OPC_ANDI:  begin opClass = OP_ARITH; arithFsel = FSEL_AND; end
            OPC_ANDIS: begin opClass = OP_ARITH; arithFsel = FSEL_AND; setFlags = 1'b1; end
            OPC_ORRI:  begin opClass = OP_ARITH; arithFsel = FSEL_ORR; end
            OPC_EORI:  begin opClass = OP_ARITH; arithFsel = FSEL_EOR; end
            default:   begin opClass = OP_ILLEGAL; end
         endcase
      end
   end

   // Next-state logic. Only MOVK needs the second MERGE cycle; illegal
   // instructions spend their one EXEC cycle and return to IDLE.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         ST_IDLE:  stateNext = accept ? ST_EXEC : ST_IDLE;
         ST_EXEC:  stateNext = (opClass == OP_MOVK) ? ST_MERGE : ST_IDLE;
         ST_MERGE: stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
   end

   // Control word and K. Everything defaults to zero so IDLE drives a
   // harmless all-zero word. MOVK first ANDs the destination with a mask that
   // clears the target halfword (Psel held), then ORs the shifted immediate
   // back in during MERGE. MOVZ ORs the shifted immediate into XZR.
   always_comb begin
      fields  = '0;
      K       = '0;
      illegal = 1'b0;
      case (stateReg)
         ST_EXEC: begin
            case (opClass)
               OP_ARITH: begin
                  fields.psel = PSEL_LOAD;
                  fields.da   = instrLatched[4:0];
                  fields.sa   = instrLatched[9:5];
                  fields.fsel = arithFsel;
                  fields.regW = 1'b1;
                  fields.dsel = DSEL_ALU;
                  fields.bsel = 1'b1;
                  fields.sl   = setFlags;
                  K           = arithK;
               end
               OP_MOVZ: begin
                  fields.psel = PSEL_LOAD;
                  fields.da   = instrLatched[4:0];
                  fields.sa   = REG_XZR;
                  fields.fsel = FSEL_ORR;
                  fields.regW = 1'b1;
                  fields.dsel = DSEL_ALU;
                  fields.bsel = 1'b1;
                  K           = movK;
               end
               OP_MOVK: begin
                  fields.psel = PSEL_HOLD;
                  fields.da   = instrLatched[4:0];
                  fields.sa   = instrLatched[4:0];
                  fields.fsel = FSEL_AND;
                  fields.regW = 1'b1;
                  fields.dsel = DSEL_ALU;
                  fields.bsel = 1'b1;
                  K           = maskK;
               end
               default: begin
                  fields.psel = PSEL_LOAD;
                  illegal     = 1'b1;
               end
            endcase
         end
         ST_MERGE: begin
            fields.psel = PSEL_LOAD;
            fields.da   = instrLatched[4:0];
            fields.sa   = instrLatched[4:0];
            fields.fsel = FSEL_ORR;
            fields.regW = 1'b1;
            fields.dsel = DSEL_ALU;
            fields.bsel = 1'b1;
            K           = movK;
         end
         default: begin
            fields  = '0;
            K       = '0;
            illegal = 1'b0;
         end
      endcase
   end

   assign controlWord = CW_WIDTH'(packControl(fields));

endmodule

// File: tb/tb_imm_control_fsm.sv
// Directed testbench for imm_control_fsm. A 64-bit and a 32-bit instance see
// the same stimulus; expected control words are assembled here from the
// documented field layout and hand-decoded instruction fields.
module tb_imm_control_fsm;

   logic        clock;
   logic        reset;
   logic        instrValid;
   logic [31:0] instruction;

   logic        ready64;
   logic [28:0] cw64;
   logic [63:0] k64;
   logic [1:0]  state64;
   logic        illegal64;

   logic        ready32;
   logic [28:0] cw32;
   logic [31:0] k32;
   logic [1:0]  state32;
   logic        illegal32;

   int checks   = 0;
   int failures = 0;

   imm_control_fsm #(.DATA_WIDTH(64), .CW_WIDTH(29)) dut64 (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instrValid),
      .instruction (instruction),
      .instr_ready (ready64),
      .controlWord (cw64),
      .K           (k64),
      .state       (state64),
      .illegal     (illegal64)
   );

   imm_control_fsm #(.DATA_WIDTH(32), .CW_WIDTH(29)) dut32 (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instrValid),
      .instruction (instruction),
      .instr_ready (ready32),
      .controlWord (cw32),
      .K           (k32),
      .state       (state32),
      .illegal     (illegal32)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Builds the expected control word from its named fields.
   function automatic logic [28:0] makeCw(input logic [1:0] psel, input logic [4:0] da,
                                          input logic [4:0] sa, input logic [4:0] fsel,
                                          input logic regW, input logic sl);
      return {psel, da, sa, 5'd0, fsel, regW, 1'b0, 2'b01, 1'b1, 1'b0, sl};
   endfunction

   // Drives the fetch-side inputs.
   task automatic applyStimulus(input logic valid, input logic [31:0] instr);
      instrValid  = valid;
      instruction = instr;
   endtask

   // Advances one clock and settles just after the edge.
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Issues a one-cycle arithmetic/logic instruction and checks EXEC and the
   // return to IDLE on the 64-bit instance.
   task automatic runArith(input string tag, input logic [31:0] instr, input logic [4:0] da,
                           input logic [4:0] sa, input logic [4:0] fsel, input logic sl,
                           input logic [63:0] kExp);
      applyStimulus(1'b1, instr);
      stepCycle();
      applyStimulus(1'b0, 32'd0);
      checkOutput({tag, "_state"}, 64'(state64), 64'd1);
      checkOutput({tag, "_cw"}, 64'(cw64), 64'(makeCw(2'b01, da, sa, fsel, 1'b1, sl)));
      checkOutput({tag, "_k"}, k64, kExp);
      stepCycle();
      checkOutput({tag, "_idle"}, 64'(state64), 64'd0);
   endtask

   // Directed sequence.
   initial begin
      applyStimulus(1'b0, 32'd0);
      reset = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("rst_state", 64'(state64), 64'd0);
      checkOutput("rst_cw", 64'(cw64), 64'd0);
      checkOutput("rst_k", k64, 64'd0);
      checkOutput("rst_illegal", 64'(illegal64), 64'd0);
      reset = 1'b0;
      stepCycle();
      checkOutput("rst_ready", 64'(ready64), 64'd1);

      // ADDI X1,X2,#5
      applyStimulus(1'b1, 32'h91001441);
      stepCycle();
      applyStimulus(1'b0, 32'd0);
      checkOutput("addi_state", 64'(state64), 64'd1);
      checkOutput("addi_ready", 64'(ready64), 64'd0);
      checkOutput("addi_cw", 64'(cw64), 64'(makeCw(2'b01, 5'd1, 5'd2, 5'b01000, 1'b1, 1'b0)));
      checkOutput("addi_k", k64, 64'd5);
      checkOutput("addi_illegal", 64'(illegal64), 64'd0);
      stepCycle();
      checkOutput("addi_idle_state", 64'(state64), 64'd0);
      checkOutput("addi_idle_cw", 64'(cw64), 64'd0);
      checkOutput("addi_idle_ready", 64'(ready64), 64'd1);

      // MOVK X3,#0xBEEF,LSL16
      applyStimulus(1'b1, 32'hF2B7DDE3);
      stepCycle();
      applyStimulus(1'b0, 32'd0);
      checkOutput("movk_exec_state", 64'(state64), 64'd1);
      checkOutput("movk_exec_cw", 64'(cw64), 64'(makeCw(2'b00, 5'd3, 5'd3, 5'b00000, 1'b1, 1'b0)));
      checkOutput("movk_exec_k", k64, 64'hFFFFFFFF0000FFFF);
      checkOutput("movk_exec_k32", 64'(k32), 64'h000000000000FFFF);
      stepCycle();
      checkOutput("movk_merge_state", 64'(state64), 64'd2);
      checkOutput("movk_merge_cw", 64'(cw64), 64'(makeCw(2'b01, 5'd3, 5'd3, 5'b00100, 1'b1, 1'b0)));
      checkOutput("movk_merge_k", k64, 64'h00000000BEEF0000);
      checkOutput("movk_merge_k32", 64'(k32), 64'h00000000BEEF0000);
      stepCycle();
      checkOutput("movk_idle_state", 64'(state64), 64'd0);

      // MOVZ X4,#1,LSL32: legal on 64 bits, illegal on 32 bits
      applyStimulus(1'b1, 32'hD2C00024);
      stepCycle();
      applyStimulus(1'b0, 32'd0);
      checkOutput("movz_cw", 64'(cw64), 64'(makeCw(2'b01, 5'd4, 5'd31, 5'b00100, 1'b1, 1'b0)));
      checkOutput("movz_k", k64, 64'h0000000100000000);
      checkOutput("movz_illegal", 64'(illegal64), 64'd0);
      checkOutput("movz32_illegal", 64'(illegal32), 64'd1);
      checkOutput("movz32_regw", 64'(cw32[6]), 64'd0);
      checkOutput("movz32_psel", 64'(cw32[28:27]), 64'd1);
      stepCycle();
      checkOutput("movz_idle_state", 64'(state64), 64'd0);
      checkOutput("movz32_idle_state", 64'(state32), 64'd0);
      checkOutput("movz32_idle_illegal", 64'(illegal32), 64'd0);

      // All-zero opcode is illegal
      applyStimulus(1'b1, 32'h00000000);
      stepCycle();
      applyStimulus(1'b0, 32'd0);
      checkOutput("ill_state", 64'(state64), 64'd1);
      checkOutput("ill_flag", 64'(illegal64), 64'd1);
      checkOutput("ill_regw", 64'(cw64[6]), 64'd0);
      checkOutput("ill_ramw", 64'(cw64[5]), 64'd0);
      checkOutput("ill_sl", 64'(cw64[0]), 64'd0);
      checkOutput("ill_psel", 64'(cw64[28:27]), 64'd1);
      checkOutput("ill_ready", 64'(ready64), 64'd0);
      stepCycle();
      checkOutput("ill_clear", 64'(illegal64), 64'd0);
      checkOutput("ill_ready_again", 64'(ready64), 64'd1);

      // Reset during MOVK MERGE aborts the instruction
      applyStimulus(1'b1, 32'hF2B7DDE3);
      stepCycle();
      applyStimulus(1'b0, 32'd0);
      stepCycle();
      checkOutput("abort_pre_state", 64'(state64), 64'd2);
      reset = 1'b1;
      stepCycle();
      checkOutput("abort_state", 64'(state64), 64'd0);
      checkOutput("abort_cw", 64'(cw64), 64'd0);
      checkOutput("abort_k", k64, 64'd0);
      reset = 1'b0;
      stepCycle();
      checkOutput("abort_after_cw", 64'(cw64), 64'd0);
      checkOutput("abort_after_ready", 64'(ready64), 64'd1);

      // Other immediate opcodes, including flag-setting forms and max imm12
      runArith("andis", 32'hF203FCC5, 5'd5, 5'd6, 5'b00000, 1'b1, 64'h0FF);
      runArith("eori", 32'hD23FFD07, 5'd7, 5'd8, 5'b01100, 1'b0, 64'hFFF);
      runArith("subis", 32'hF1000549, 5'd9, 5'd10, 5'b01001, 1'b1, 64'h1);

      // instr_valid held high: one accept every two cycles
      applyStimulus(1'b1, 32'h91001441);
      for (int i = 0; i < 6; i++) begin
         stepCycle();
         checkOutput($sformatf("b2b_state_%0d", i), 64'(state64), (i % 2 == 0) ? 64'd1 : 64'd0);
         checkOutput($sformatf("b2b_ready_%0d", i), 64'(ready64), (i % 2 == 0) ? 64'd0 : 64'd1);
      end
      applyStimulus(1'b0, 32'd0);
      stepCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_control_fsm.md
IMM_CONTROL_FSM -- requirements
Module: imm_control_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning datapath and K width (32 or 64).
REQ-002 SHALL have parameter CW_WIDTH, default 29, meaning control word width {Psel2,DA5,SA5,SB5,Fsel5,regW,ramW,Dsel2,Bsel,PCsel,SL}.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port instr_valid  input  1  instruction offered by fetch.
REQ-006 SHALL have port instruction  input  32  LEGv8 instruction word.
REQ-007 SHALL have port instr_ready  output  1  FSM can accept an instruction.
REQ-008 SHALL have port controlWord  output  CW_WIDTH  datapath control word.
REQ-009 SHALL have port K  output  DATA_WIDTH  immediate operand to datapath B input.
REQ-010 SHALL have port state  output  2  current state (IDLE=00, EXEC=01, MERGE=10).
REQ-011 SHALL have port illegal  output  1  one-cycle flag for an undecodable or out-of-range instruction.

Function
REQ-012 SHALL decode ADDI/ADDIS/SUBI/SUBIS/ANDI/ANDIS/ORRI/EORI on instruction[31:22], and MOVZ/MOVK on instruction[31:23].
REQ-013 SHALL assert instr_ready only in IDLE; an instruction is accepted when instr_valid and instr_ready are both 1, and it is latched that edge.
REQ-014 SHALL transition IDLE->EXEC on accept; EXEC->MERGE for MOVK; EXEC->IDLE otherwise; MERGE->IDLE unconditionally.
REQ-015 SHALL drive controlWord all-zero in IDLE (Psel=00, regW=0, ramW=0).
REQ-016 SHALL compute controlWord and K combinationally from the latched instruction and state; the output latency from accept is one cycle.
REQ-017 Arithmetic/logic EXEC: DA=Rd[4:0], SA=Rn[9:5], SB=0, Bsel=1, Dsel=01, regW=1, ramW=0, PCsel=0, Psel=01, K=zero-extended instruction[21:10].
REQ-018 Fsel SHALL be AND=00000, ORR=00100, ADD=01000, SUB=01001, EOR=01100; SL=1 only for ADDIS/SUBIS/ANDIS.
REQ-019 shift = 16*instruction[22:21]; imm16 = instruction[20:5].
REQ-020 MOVZ EXEC: SA=31 (XZR), Fsel=ORR, K=imm16<<shift, Psel=01, regW=1.
REQ-021 MOVK EXEC: SA=DA=Rd, Fsel=AND, K=~(0xFFFF<<shift), Psel=00, regW=1.
REQ-022 MOVK MERGE: SA=DA=Rd, Fsel=ORR, K=imm16<<shift, Psel=01, regW=1.
REQ-023 If DATA_WIDTH=32 and instruction[22]=1 on MOVZ/MOVK, the instruction SHALL be treated as illegal.
REQ-024 Illegal instruction: one EXEC cycle with regW=0, ramW=0, SL=0, Psel=01, illegal=1, then IDLE.
REQ-025 instr_valid in EXEC or MERGE SHALL be ignored; fetch holds the instruction until instr_ready.

Reset
REQ-026 On reset: state=IDLE, latched instruction=0, illegal=0, controlWord=0, K=0, instr_ready=1 the cycle after reset deasserts.
REQ-027 Reset in EXEC or MERGE SHALL abort the instruction; no further regW=1 cycle for it.

Structure
REQ-028 Shared package SHALL hold state encodings, Fsel constants, opcode constants, and control-word field offsets.
REQ-029 One sub-module, imm_k_gen (K and mask generation from imm12/imm16/hw, parameterised by DATA_WIDTH), is natural.

Verification
REQ-030 0x91001441 (ADDI X1,X2,#5) -> EXEC: DA=1, SA=2, Fsel=01000, K=5, regW=1, Psel=01, SL=0; IDLE next.
REQ-031 0xF2B7DDE3 (MOVK X3,#0xBEEF,LSL16) -> EXEC K=0xFFFFFFFF0000FFFF Fsel=AND Psel=00; MERGE K=0x00000000BEEF0000 Fsel=ORR Psel=01.
REQ-032 0xD2C00024 (MOVZ X4,#1,LSL32), DATA_WIDTH=64 -> K=0x0000000100000000, SA=31; DATA_WIDTH=32 -> illegal=1, regW=0.
REQ-033 Opcode 0x00000000 -> illegal=1 for one cycle, Psel=01, regW=0, ready again after 2 cycles.
REQ-034 Reset asserted during MOVK MERGE -> next cycle state=00, controlWord=0, no regW.
REQ-035 instr_valid held high with back-to-back ADDIs -> one accept per 2 cycles, ready low in EXEC.
